// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, counter sizing and
// the divide-by-zero quotient constant.
package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH_DEF = 32;

  // Bit counter must hold the value WIDTH itself.
  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DIV_CNT_W = $clog2(DIV_WIDTH_DEF + 1);

  // All-ones quotient returned on divide-by-zero; sliced to WIDTH (<= 64).
  localparam logic [63:0] DIV_DBZ_QUO = '1;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational N-bit subtractor (a + ~b + 1) built from 4-bit
// carry-lookahead groups with a group-level carry lookahead.
// neg_o is the borrow out, i.e. a < b treating both as unsigned.
module div_trial_sub #(
  parameter int N = 33
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         neg_o
);

  // Operands are zero-extended to whole groups; the borrow is unaffected.
  localparam int NG = (N + 3) / 4;
  localparam int NP = NG * 4;

  logic [NP-1:0] a_p, bn_p, g, p, c, s;
  logic [NG-1:0] gg, pp;
  logic [NG:0]   gc;
  logic [NP-1:0] unused_s;

  assign a_p  = NP'(a_i);
  assign bn_p = ~(NP'(b_i));

  // Bit generate/propagate, group lookahead, then in-group carries.
  always_comb begin
    g     = a_p & bn_p;
    p     = a_p ^ bn_p;
    c     = '0;
    gg    = '0;
    pp    = '0;
    gc    = '0;
    gc[0] = 1'b1;
    for (int k = 0; k < NG; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pp[k] = &p[4*k +: 4];
      gc[k+1] = gg[k] | (pp[k] & gc[k]);
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign s        = p ^ c;
  assign unused_s = s;
  assign diff_o   = s[N-1:0];
  assign neg_o    = ~gc[NG];

endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on
// operand magnitudes, sign fix-up at the end, results held until the
// next accepted start.
module div_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = div_cnt_w(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dmag_q, dmag_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0] quot_q, quot_d, remr_q, remr_d;
  logic             dbz_q, dbz_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   partial, trial;
  logic             trial_neg;
  logic             unused_trial_msb;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor  : divisor;

  // Shifted partial remainder picks up the next dividend bit from quo MSB.
  assign partial = {rem_q, quo_q[WIDTH-1]};

  div_trial_sub #(.N(WIDTH + 1)) u_sub (
    .a_i    (partial),
    .b_i    ({1'b0, dmag_q}),
    .diff_o (trial),
    .neg_o  (trial_neg)
  );

  // Trial difference is below the divisor whenever it is kept, so its MSB is 0.
  assign unused_trial_msb = trial[WIDTH];

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    remr_d  = remr_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          qneg_d = dvd_neg ^ dvs_neg;
          rneg_d = dvd_neg;
          dmag_d = dvs_mag;
          quo_d  = dvd_mag;
          rem_d  = '0;
          cnt_d  = CNT_W'(WIDTH);
          if (divisor == '0) begin
            quot_d  = DIV_DBZ_QUO[WIDTH-1:0];
            remr_d  = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!trial_neg) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = partial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        quot_d  = qneg_q ? -quo_q : quo_q;
        remr_d  = rneg_q ? -rem_q : rem_q;
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and visible results; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      quot_q  <= '0;
      remr_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      remr_q  <= remr_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dmag_q <= dmag_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = remr_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq (WIDTH=32): stimulus pushes hand-computed
// results, a negedge monitor pops and compares on every done pulse.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  div_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   last_acc = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 at edge %0d required no done", cyc + 1);
      end else begin
        mon_e = sb.pop_front();
        check32("quotient", quotient, mon_e.q);
        check32("remainder", remainder, mon_e.r);
        check32("div_by_zero", {31'b0, div_by_zero}, {31'b0, mon_e.dbz});
        check32("done_edge", 32'(cyc + 1), 32'(mon_e.edge_n));
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                       input bit push);
    exp_t e;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    last_acc = cyc;
    if (push) begin
      e.q      = eq;
      e.r      = er;
      e.dbz    = edbz;
      e.edge_n = last_acc + ((b == 32'd0) ? 1 : 34);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d results pending required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                     input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    issue(a, b, sgn, eq, er, edbz, 1'b1);
    drain();
  endtask

  task automatic pulse_start_at(input int edge_n, input logic [31:0] a, input logic [31:0] b);
    while (cyc < edge_n - 1) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    bit busy_ok;

    // Reset state
    repeat (2) @(negedge clk);
    check32("reset_busy", {31'b0, busy}, 32'd0);
    check32("reset_done", {31'b0, done}, 32'd0);
    check32("reset_quotient", quotient, 32'd0);
    check32("reset_remainder", remainder, 32'd0);
    check32("reset_dbz", {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. unsigned 100/7 with busy window
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1);
    busy_ok = 1'b1;
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check32("busy_window", {31'b0, busy_ok}, 32'd1);
    @(negedge clk);
    check32("busy_at_done", {31'b0, busy}, 32'd0);
    drain();

    // 2. signed and unsigned interpretations of 0xFFFFFFF9 / 2, other sign mixes
    run(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0);
    run(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 32'd2, 32'hFFFF_FFFE, 1'b0);

    // 3. divide by zero in both modes, then a normal divide clears the flag
    run(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

    // 4. signed overflow MIN / -1
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);

    // 5. starts during RUN, FIX and DONE are ignored
    issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 1'b1);
    pulse_start_at(last_acc + 5, 32'd77, 32'd5);
    pulse_start_at(last_acc + 33, 32'd78, 32'd4);
    pulse_start_at(last_acc + 34, 32'd79, 32'd3);
    drain();
    repeat (40) @(negedge clk);
    check32("no_second_run_busy", {31'b0, busy}, 32'd0);
    check32("held_quotient", quotient, 32'd100);

    // 6. asynchronous reset mid-run, then a fresh divide
    issue(32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    while (cyc < last_acc + 9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check32("abort_busy", {31'b0, busy}, 32'd0);
    check32("abort_done", {31'b0, done}, 32'd0);
    check32("abort_quotient", quotient, 32'd0);
    check32("abort_remainder", remainder, 32'd0);
    check32("abort_dbz", {31'b0, div_by_zero}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check32("after_abort_busy", {31'b0, busy}, 32'd0);
    run(32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
